// File: rtl/minbd_injector.sv
// MinBD local injection unit: queues core packets and drops them into empty router input slots.
// Optional starvation detection is enabled by defining MINBD_INJ_STARVE_EN.
module minbd_injector #(
    parameter int unsigned FLIT_W       = 11,
    parameter int unsigned DEPTH        = 4
`ifdef MINBD_INJ_STARVE_EN
    ,
    parameter int unsigned STARVE_LIMIT = 8
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      core_valid,
    output logic                      core_ready,
    input  logic [3:0]                core_dest,
    input  logic [5:0]                core_data,
    input  logic [FLIT_W-1:0]         link_in,
    output logic [FLIT_W-1:0]         link_out,
    output logic                      inj_fire,
`ifdef MINBD_INJ_STARVE_EN
    output logic                      starve,
`endif
    output logic [$clog2(DEPTH):0]    fifo_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = FLIT_W - 1;

    typedef struct packed {
        logic [3:0] dest;
        logic [5:0] data;
    } inj_entry_t;

`ifdef MINBD_INJ_STARVE_EN
    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_STARVED} state_t;
`else
    typedef enum logic [0:0] {ST_IDLE, ST_PEND} state_t;
`endif

    state_t             state;
    state_t             state_nxt;
    inj_entry_t         mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               link_busy;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               last_pop;

    assign core_ready = (fifo_count != CNT_W'(DEPTH));
    assign link_busy  = link_in[FLIT_W-1];
    assign fifo_empty = (fifo_count == '0);
    assign push       = core_valid && core_ready;
    assign pop        = !link_busy && !fifo_empty;
    assign last_pop   = pop && !push && (fifo_count == CNT_W'(1));

`ifdef MINBD_INJ_STARVE_EN
    logic [3:0] blk_cnt;

    // Counts consecutive cycles a queued packet is denied a slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt <= '0;
        end else if (fifo_empty || pop) begin
            blk_cnt <= '0;
        end else if (link_busy && (blk_cnt != 4'(STARVE_LIMIT))) begin
            blk_cnt <= blk_cnt + 4'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
`ifdef MINBD_INJ_STARVE_EN
            starve <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
`ifdef MINBD_INJ_STARVE_EN
            starve <= (state_nxt == ST_STARVED);
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (push) state_nxt = ST_PEND;
            end
            ST_PEND: begin
                if (last_pop) begin
                    state_nxt = ST_IDLE;
`ifdef MINBD_INJ_STARVE_EN
                end else if (!pop && (blk_cnt == 4'(STARVE_LIMIT))) begin
                    state_nxt = ST_STARVED;
`endif
                end
            end
`ifdef MINBD_INJ_STARVE_EN
            ST_STARVED: begin
                if (pop) state_nxt = last_pop ? ST_IDLE : ST_PEND;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Storage array carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= inj_entry_t'({core_dest, core_data});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // In-flight flits always win the slot; idle slots never leak stale payload bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_out <= '0;
            inj_fire <= 1'b0;
        end else if (link_busy) begin
            link_out <= link_in;
            inj_fire <= 1'b0;
        end else if (pop) begin
            link_out <= {1'b1, ENT_W'(mem[rd_ptr])};
            inj_fire <= 1'b1;
        end else begin
            link_out <= '0;
            inj_fire <= 1'b0;
        end
    end

endmodule

// File: tb/tb_minbd_injector.sv
// Directed self-checking bench for minbd_injector; covers the starvation path when MINBD_INJ_STARVE_EN is set.
module tb_minbd_injector;

    logic        clk;
    logic        rst_n;
    logic        core_valid;
    logic        core_ready;
    logic [3:0]  core_dest;
    logic [5:0]  core_data;
    logic [10:0] link_in;
    logic [10:0] link_out;
    logic        inj_fire;
    logic [2:0]  fifo_count;
`ifdef MINBD_INJ_STARVE_EN
    logic        starve;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    minbd_injector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_valid (core_valid),
        .core_ready (core_ready),
        .core_dest  (core_dest),
        .core_data  (core_data),
        .link_in    (link_in),
        .link_out   (link_out),
        .inj_fire   (inj_fire),
`ifdef MINBD_INJ_STARVE_EN
        .starve     (starve),
`endif
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(input logic v, input logic [3:0] d, input logic [5:0] p);
        core_valid = v;
        core_dest  = d;
        core_data  = p;
    endtask

    function automatic logic [10:0] flit(input logic [3:0] d, input logic [5:0] p);
        return {1'b1, d, p};
    endfunction

    function automatic logic [3:0] sdest(input int j);
        return 4'(j * 3 + 1);
    endfunction

    function automatic logic [5:0] sdata(input int j);
        return 6'(j * 5 + 7);
    endfunction

    initial begin
        rst_n   = 1'b0;
        link_in = '0;
        offer(1'b0, 4'h0, 6'h0);
        step();
        step();
        check("rst_link_out", 32'(link_out), 32'h0);
        check("rst_inj_fire", 32'(inj_fire), 32'h0);
        check("rst_count", 32'(fifo_count), 32'h0);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 32'(core_ready), 32'h1);
        @(negedge clk);

        // Idle-link injection: two-cycle minimum latency.
        offer(1'b1, 4'b1001, 6'b101100);
        step();
        offer(1'b0, 4'h0, 6'h0);
        check("idle_cnt1", 32'(fifo_count), 32'h1);
        check("idle_noflit", 32'(link_out), 32'h0);
        step();
        check("idle_flit", 32'(link_out), 32'(11'b11001101100));
        check("idle_fire", 32'(inj_fire), 32'h1);
        check("idle_cnt0", 32'(fifo_count), 32'h0);
        step();
        check("idle_fire_off", 32'(inj_fire), 32'h0);

        // Pass-through priority, then stale-bit suppression on an invalid slot.
        link_in = 11'b10010101100;
        offer(1'b1, 4'b0110, 6'b000111);
        step();
        offer(1'b0, 4'h0, 6'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("pass_link", 32'(link_out), 32'(11'b10010101100));
            check("pass_fire", 32'(inj_fire), 32'h0);
            check("pass_cnt", 32'(fifo_count), 32'h1);
        end
        link_in = 11'b00111111111;
        step();
        check("pass_inject", 32'(link_out), 32'(11'b10110000111));
        check("pass_inj_fire", 32'(inj_fire), 32'h1);
        check("pass_cnt0", 32'(fifo_count), 32'h0);
        step();
        check("stale_zero", 32'(link_out), 32'h0);

        // Fill under a busy link, hold a fifth offer, then drain in order.
        link_in = 11'b10000000001;
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, sdest(i + 20), sdata(i + 20));
            step();
        end
        check("full_cnt", 32'(fifo_count), 32'h4);
        check("full_ready", 32'(core_ready), 32'h0);
        offer(1'b1, 4'hF, 6'h3F);
        step();
        step();
        check("full_hold_cnt", 32'(fifo_count), 32'h4);
        check("full_hold_link", 32'(link_out), 32'(11'b10000000001));
        link_in = '0;
        offer(1'b0, 4'h0, 6'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_flit", 32'(link_out), 32'(flit(sdest(i + 20), sdata(i + 20))));
            check("drain_cnt", 32'(fifo_count), 32'(3 - i));
            check("drain_ready", 32'(core_ready), 32'h1);
        end
        step();
        check("drain_idle", 32'(link_out), 32'h0);

        // Streaming push/pop every cycle; pointers wrap several times.
        for (int j = 0; j < 10; j++) begin
            offer(1'b1, sdest(j), sdata(j));
            step();
            check("strm_cnt", 32'(fifo_count), 32'h1);
            if (j > 0) check("strm_flit", 32'(link_out), 32'(flit(sdest(j - 1), sdata(j - 1))));
        end
        offer(1'b0, 4'h0, 6'h0);
        step();
        check("strm_last", 32'(link_out), 32'(flit(sdest(9), sdata(9))));
        check("strm_cnt0", 32'(fifo_count), 32'h0);

`ifdef MINBD_INJ_STARVE_EN
        // Eight blocked cycles after the push, flag rises on the following edge.
        link_in = 11'b10101010101;
        offer(1'b1, 4'b0011, 6'b010101);
        step();
        offer(1'b0, 4'h0, 6'h0);
        for (int i = 0; i < 8; i++) step();
        check("starve_pre", 32'(starve), 32'h0);
        step();
        check("starve_set", 32'(starve), 32'h1);
        link_in = '0;
        step();
        check("starve_inject", 32'(link_out), 32'(11'b10011010101));
        check("starve_clr", 32'(starve), 32'h0);
        check("starve_cnt0", 32'(fifo_count), 32'h0);
`endif

        // Asynchronous reset mid-operation discards queued packets.
        link_in = 11'b11111111111;
        offer(1'b1, 4'h5, 6'h2A);
        step();
        step();
        offer(1'b0, 4'h0, 6'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_link", 32'(link_out), 32'h0);
        check("arst_cnt", 32'(fifo_count), 32'h0);
        check("arst_fire", 32'(inj_fire), 32'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        link_in = '0;
        step();
        check("arst_noinj", 32'(inj_fire), 32'h0);
        check("arst_nolink", 32'(link_out), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/minbd_injector.md
Name: minbd_injector

Overview:
- Local-node injection unit for the MinBD bufferless deflection router. Accepts packets from the local core over a valid/ready handshake and queues them in a small FIFO.
- Packs each queued packet into an 11-bit flit and inserts it into the router's incoming pipeline slot only when that slot carries no flit.
- Sits between the local core and the router input, ahead of the permutation deflection network. It is the transmitting end of the flit link that the network consumes.

Parameters:
- FLIT_W, 11, flit width. Format: [10] valid, [9:8] dest_x, [7:6] dest_y, [5:0] payload.
- DEPTH, 4, injection FIFO entries; power of two, minimum 2.
- STARVE_LIMIT, 8, consecutive blocked cycles before starvation is flagged (used only with STARVE_EN).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- core_valid, input, 1, core offers a packet.
- core_ready, output, 1, injector accepts the packet this cycle.
- core_dest, input, 4, destination {x[1:0], y[1:0]}.
- core_data, input, 6, payload.
- link_in, input, 11, flit arriving in this router input slot; bit 10 is valid.
- link_out, output, 11, registered flit forwarded to the router.
- inj_fire, output, 1, registered pulse: link_out holds a flit injected from the FIFO.
- fifo_count, output, log2(DEPTH)+1, current occupancy.
- starve, output, 1, starvation flag (exists only with STARVE_EN).

Behaviour:
- Reset (async, rst_n=0): link_out=0, inj_fire=0, fifo_count=0, read/write pointers=0, state=IDLE, starve=0. core_ready goes to 1 once reset releases.
- core_ready = (fifo_count != DEPTH). It is combinational from count only and does not depend on a same-cycle pop.
- Push: when core_valid && core_ready at a clock edge, write {dest, data} (10 bits) at wr_ptr, then wr_ptr++. Pointers wrap modulo DEPTH.
- Priority per cycle, evaluated at the clock edge:
  - link_in[10]=1: link_out <= link_in. The in-flight flit always wins. inj_fire <= 0. No pop.
  - else if FIFO non-empty: link_out <= {1'b1, head}. rd_ptr++. inj_fire <= 1.
  - else: link_out <= 11'b0 and inj_fire <= 0.
- An invalid link_in (bit 10=0) is never forwarded with stale payload bits; the output is all-zero.
- Latency: with an empty FIFO and an idle link, a packet accepted at edge N appears on link_out after edge N+1. Minimum latency is 2 cycles; there is no bypass.
- Simultaneous push and pop: fifo_count is unchanged, and both pointers advance.
- Push while full: impossible, because core_ready=0. A core_valid held while full is simply not accepted and does not corrupt the FIFO.
- FSM:
  - IDLE (count=0): a push moves to PEND.
  - PEND (count>0): a pop that empties the FIFO with no simultaneous push returns to IDLE.
  - With STARVE_EN, PEND goes to STARVED once the block counter reaches STARVE_LIMIT.
  - STARVED returns to PEND on the next injection, or to IDLE if that injection empties the FIFO.
- fifo_count always equals pushes minus pops since reset, in the range 0..DEPTH.
- Reset mid-operation: FIFO contents are discarded (pointers and count cleared). link_out clears immediately, asynchronously.

Optional Feature:
- Macro: MINBD_INJ_STARVE_EN.
- Enabled:
  - A 4-bit block counter increments each cycle that the FIFO is non-empty and link_in[10]=1, saturating at STARVE_LIMIT.
  - The counter clears on any injection or when the FIFO is empty.
  - starve = (state==STARVED) is registered and drives the upstream throttle request.
- Disabled: the starve port, the counter and the STARVED state are absent. The FSM has only IDLE and PEND.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> link_out=0, inj_fire=0 and fifo_count=0 immediately. After release, core_ready=1.
- Idle-link injection: push dest=4'b1001, data=6'b101100 while link_in=0 -> two edges later link_out=11'b11001101100 and inj_fire=1, then fifo_count=0.
- Pass-through priority: FIFO holds 1 entry and link_in=11'b10010101100 for 3 cycles -> link_out equals link_in each cycle, inj_fire=0 and fifo_count stays 1. The first idle cycle injects the entry.
- Full and back-pressure: hold link_in valid and push 4 packets -> fifo_count=4 and core_ready=0. A fifth packet held with core_valid=1 is not accepted. Release the link -> 4 injections occur in order, and core_ready=1 after the first pop.
- Simultaneous push/pop plus wrap: stream 10 packets with link_in idle -> fifo_count stays at 1 in steady state, pointers wrap without loss, and output order matches input order.
- Starvation (MINBD_INJ_STARVE_EN): FIFO non-empty and link_in valid for 8 cycles -> starve=1 on the following cycle. One idle slot injects the entry and starve returns to 0.
